spi_slave_param: RTL and testbench
==================================

SPI_SLAVE_PARAM -- requirements
Module: spi_slave_param

Interface
REQ-001 Parameter DATA_SIZE, default 8, payload bits per frame; SHALL be >= 2.
REQ-002 Parameter TX_TIMEOUT, default 15, max clk edges in WAIT_TX awaiting tx_valid; SHALL be >= 1.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 SS_n  input  1  slave select, active low; frames only while low.
REQ-006 MOSI  input  1  serial data in, MSB first, one bit per clk edge.
REQ-007 MISO  output  1  serial read data out, MSB first, registered.
REQ-008 tx_data  input  DATA_SIZE  read data from downstream memory.
REQ-009 tx_valid  input  1  tx_data valid strobe.
REQ-010 rx_data  output  DATA_SIZE+2  received frame {cmd[1:0], payload}, registered.
REQ-011 rx_valid  output  1  one-cycle pulse, rx_data valid.
REQ-012 busy  output  1  high whenever state != IDLE.

Function
REQ-013 States SHALL be IDLE, CMD, SHIFT, WAIT_TX, SEND, DONE; N = DATA_SIZE+2 bits per frame.
REQ-014 IDLE -> CMD at first edge E0 sampling SS_n low; no bit is sampled at E0.
REQ-015 Bits SHALL be sampled at edges E1..EN: E1 in CMD (cmd MSB), E2..EN in SHIFT; bit counter width clog2(N+1).
REQ-016 At EN, rx_data SHALL load the full N-bit frame, including the bit sampled at EN, and rx_valid SHALL be high for exactly the following cycle.
REQ-017 cmd 00 (write addr), 01 (write data), 10 (read addr) -> DONE after EN; cmd 10 SHALL set internal rd_addr_done.
REQ-018 cmd 11 with rd_addr_done=1 -> WAIT_TX after EN and clear rd_addr_done; cmd 11 with rd_addr_done=0 -> DONE with no MISO transfer.
REQ-019 WAIT_TX: at the first edge sampling tx_valid=1, the block SHALL latch tx_data, drive MISO=tx_data[DATA_SIZE-1], and enter SEND.
REQ-020 SEND SHALL drive the remaining DATA_SIZE-1 bits on the next DATA_SIZE-1 edges, then set MISO=0 and enter DONE.
REQ-021 WAIT_TX SHALL go to DONE at the TX_TIMEOUT-th edge with tx_valid low; if tx_valid is high at that edge, the load wins.
REQ-022 DONE SHALL ignore MOSI, tx_valid and tx_data, and SHALL hold until SS_n is sampled high.
REQ-023 SS_n sampled high in any state -> IDLE next edge; a partial frame SHALL be discarded with no rx_valid, and SS_n high overrides all other transitions.
REQ-024 MISO SHALL be 0 in every state except SEND and the load edge of WAIT_TX.
REQ-025 rx_data SHALL hold its last value between frames.

Reset
REQ-026 rst_n low SHALL immediately force state=IDLE, MISO=0, rx_data=0, rx_valid=0, busy=0, rd_addr_done=0, all counters=0 (and err=0 when present).
REQ-027 Reset mid-frame or mid-SEND SHALL abort silently; the first edge after release SHALL behave as IDLE.

Configuration
REQ-028 Macro SPI_SLAVE_ERR_EN defined: output port err (1 bit) SHALL exist and pulse high one cycle on an aborted frame (SS_n high in CMD/SHIFT/WAIT_TX/SEND), a WAIT_TX timeout, or cmd 11 with rd_addr_done=0.
REQ-029 Macro SPI_SLAVE_ERR_EN undefined: port err SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-030 DATA_SIZE=8; SS_n low; MOSI 00_1010_0101 over E1..E10 -> rx_data=0x0A5, rx_valid high exactly one cycle, then DONE until SS_n high.
REQ-031 Frame 10_0000_0011, SS_n high, then frame 11_xxxx_xxxx with tx_valid=1 and tx_data=0xC3 three edges after E10 -> MISO 1,1,0,0,0,0,1,1 on 8 consecutive edges starting at the tx_valid edge.
REQ-032 Read-addr frame, then read-data frame with tx_valid held low -> DONE after 15 WAIT_TX edges, MISO=0 throughout; err pulse when SPI_SLAVE_ERR_EN is defined.
REQ-033 SS_n high after E5 of a write frame -> IDLE next edge, no rx_valid, rx_data unchanged; err pulse when SPI_SLAVE_ERR_EN is defined.
REQ-034 rst_n asserted during SEND bit 3 -> MISO=0, busy=0 immediately; a following read-data frame without a new read-addr frame produces no MISO transfer.
REQ-035 Read-data frame issued with no preceding read-addr frame -> rx_valid pulse, MISO stays 0, DONE; err pulse when SPI_SLAVE_ERR_EN is defined.

Source files
------------

// File: rtl/spi_slave_param.sv
// Parameterised SPI-style frame slave: receives {cmd[1:0], payload} frames and serves read data.
// Define SPI_SLAVE_ERR_EN to add the err_o pulse output.
module spi_slave_param #(
    parameter int unsigned DATA_SIZE  = 8,
    parameter int unsigned TX_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ss_n_i,
    input  logic                 mosi_i,
    output logic                 miso_o,
    input  logic [DATA_SIZE-1:0] tx_data_i,
    input  logic                 tx_valid_i,
    output logic [DATA_SIZE+1:0] rx_data_o,
    output logic                 rx_valid_o,
`ifdef SPI_SLAVE_ERR_EN
    output logic                 err_o,
`endif
    output logic                 busy_o
);

    localparam int unsigned FrameLen = DATA_SIZE + 2;
    localparam int unsigned CntW     = $clog2(FrameLen + 1);
    localparam int unsigned TmrW     = $clog2(TX_TIMEOUT + 1);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StCmd    = 3'd1;
    localparam logic [2:0] StShift  = 3'd2;
    localparam logic [2:0] StWaitTx = 3'd3;
    localparam logic [2:0] StSend   = 3'd4;
    localparam logic [2:0] StDone   = 3'd5;

    logic [2:0]           state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [TmrW-1:0]      tmr_q, tmr_d;
    logic [FrameLen-2:0]  shift_q, shift_d;
    logic [DATA_SIZE-1:0] tx_sh_q, tx_sh_d;
    logic                 miso_q, miso_d;
    logic [FrameLen-1:0]  rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rd_addr_done_q, rd_addr_done_d;

    // The bit on mosi_i at the last edge completes the frame together with the shifted bits.
    logic [FrameLen-1:0] frame;
    logic [1:0]          cmd;
    logic                frame_end;
    logic                tmr_expired;

    assign frame       = {shift_q, mosi_i};
    assign cmd         = frame[FrameLen-1 -: 2];
    assign frame_end   = (state_q == StShift) && (cnt_q == CntW'(FrameLen - 1));
    assign tmr_expired = (tmr_q == TmrW'(TX_TIMEOUT - 1));

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        tmr_d          = tmr_q;
        shift_d        = shift_q;
        tx_sh_d        = tx_sh_q;
        miso_d         = 1'b0;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        rd_addr_done_d = rd_addr_done_q;

        if (ss_n_i) begin
            // Deselect wins over everything; partial frames are dropped.
            state_d = StIdle;
            cnt_d   = '0;
            tmr_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StCmd;
                    cnt_d   = '0;
                end
                StCmd: begin
                    shift_d = {shift_q[FrameLen-3:0], mosi_i};
                    cnt_d   = CntW'(1);
                    state_d = StShift;
                end
                StShift: begin
                    if (frame_end) begin
                        rx_data_d  = frame;
                        rx_valid_d = 1'b1;
                        cnt_d      = '0;
                        tmr_d      = '0;
                        if (cmd == 2'b11) begin
                            if (rd_addr_done_q) begin
                                rd_addr_done_d = 1'b0;
                                state_d        = StWaitTx;
                            end else begin
                                state_d = StDone;
                            end
                        end else begin
                            if (cmd == 2'b10) begin
                                rd_addr_done_d = 1'b1;
                            end
                            state_d = StDone;
                        end
                    end else begin
                        shift_d = {shift_q[FrameLen-3:0], mosi_i};
                        cnt_d   = cnt_q + CntW'(1);
                    end
                end
                StWaitTx: begin
                    if (tx_valid_i) begin
                        tx_sh_d = {tx_data_i[DATA_SIZE-2:0], 1'b0};
                        miso_d  = tx_data_i[DATA_SIZE-1];
                        cnt_d   = '0;
                        tmr_d   = '0;
                        state_d = StSend;
                    end else if (tmr_expired) begin
                        tmr_d   = '0;
                        state_d = StDone;
                    end else begin
                        tmr_d = tmr_q + TmrW'(1);
                    end
                end
                StSend: begin
                    if (cnt_q == CntW'(DATA_SIZE - 1)) begin
                        cnt_d   = '0;
                        state_d = StDone;
                    end else begin
                        miso_d  = tx_sh_q[DATA_SIZE-1];
                        tx_sh_d = {tx_sh_q[DATA_SIZE-2:0], 1'b0};
                        cnt_d   = cnt_q + CntW'(1);
                    end
                end
                StDone: begin
                    state_d = StDone;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            tmr_q          <= '0;
            shift_q        <= '0;
            tx_sh_q        <= '0;
            miso_q         <= 1'b0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rd_addr_done_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            tmr_q          <= tmr_d;
            shift_q        <= shift_d;
            tx_sh_q        <= tx_sh_d;
            miso_q         <= miso_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rd_addr_done_q <= rd_addr_done_d;
        end
    end

`ifdef SPI_SLAVE_ERR_EN
    logic err_q, err_d;
    logic abort_evt, timeout_evt, noaddr_evt;

    assign abort_evt   = ss_n_i && ((state_q == StCmd) || (state_q == StShift) ||
                                    (state_q == StWaitTx) || (state_q == StSend));
    assign timeout_evt = !ss_n_i && (state_q == StWaitTx) && !tx_valid_i && tmr_expired;
    assign noaddr_evt  = !ss_n_i && frame_end && (cmd == 2'b11) && !rd_addr_done_q;

    always_comb begin
        err_d = abort_evt || timeout_evt || noaddr_evt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`endif

    assign miso_o     = miso_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign busy_o     = (state_q != StIdle);

endmodule

// File: tb/tb_spi_slave_param.sv
// Randomised frame-level bench for spi_slave_param; expectations come from a per-cycle
// transaction timeline built as each frame is driven.
`timescale 1ns/1ps
module tb_spi_slave_param;

    localparam int unsigned DS = 8;
    localparam int unsigned TO = 15;
    localparam int unsigned N  = DS + 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ss_n = 1'b1;
    logic          mosi = 1'b0;
    logic          tx_valid = 1'b0;
    logic [DS-1:0] tx_data = '0;
    logic          miso;
    logic          rx_valid;
    logic          busy;
    logic [N-1:0]  rx_data;
`ifdef SPI_SLAVE_ERR_EN
    logic          err;
`endif

    always #5 clk = ~clk;

    spi_slave_param #(
        .DATA_SIZE (DS),
        .TX_TIMEOUT(TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ss_n_i    (ss_n),
        .mosi_i    (mosi),
        .miso_o    (miso),
        .tx_data_i (tx_data),
        .tx_valid_i(tx_valid),
        .rx_data_o (rx_data),
        .rx_valid_o(rx_valid),
`ifdef SPI_SLAVE_ERR_EN
        .err_o     (err),
`endif
        .busy_o    (busy)
    );

    typedef struct {
        logic         busy;
        logic         miso;
        logic         rxv;
        logic         err;
        logic         tag;
        logic [N-1:0] rxd;
    } exp_t;

    exp_t          q[$];
    int            n_total = 0;
    int            n_pass  = 0;
    bit            armed   = 1'b0;
    logic [N-1:0]  last_rx = '0;
    int            rxv_cnt = 0;
    int            miso_hi_cnt = 0;
    int            tag_cnt = 0;
    logic [DS-1:0] miso_bits = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [DS-1:0] rd();
        return DS'($urandom);
    endfunction

    // Compare process: one expectation per clock edge while the queue is populated.
    initial begin : cmp
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rx_valid === 1'b1) rxv_cnt++;
            if (miso === 1'b1) miso_hi_cnt++;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("busy", 32'(busy), 32'(e.busy));
                chk("miso", 32'(miso), 32'(e.miso));
                chk("rx_valid", 32'(rx_valid), 32'(e.rxv));
                chk("rx_data", 32'(rx_data), 32'(e.rxd));
`ifdef SPI_SLAVE_ERR_EN
                chk("err", 32'(err), 32'(e.err));
`endif
                if (e.tag) begin
                    miso_bits = {miso_bits[DS-2:0], miso};
                    tag_cnt++;
                end
            end
        end
    end

    task automatic step(input bit ss, input bit mo, input bit tv, input logic [DS-1:0] td,
                        input bit eb, input bit em, input bit erv, input bit ee, input bit tg);
        exp_t e;
        @(negedge clk);
        ss_n     = ss;
        mosi     = mo;
        tx_valid = tv;
        tx_data  = td;
        e.busy = eb;
        e.miso = em;
        e.rxv  = erv;
        e.err  = ee;
        e.tag  = tg;
        e.rxd  = last_rx;
        q.push_back(e);
    endtask

    task automatic flush();
        for (int g = 0; g < 8 && q.size() != 0; g++) @(posedge clk);
        #2;
    endtask

    // Drives one frame and records the outputs the rules require after every edge.
    // abort_bits: deselect instead of sampling that bit; send_cut: return (still selected)
    // after the load edge plus that many SEND bits.
    task automatic frame(input logic [1:0] cmd, input logic [DS-1:0] pay, input int abort_bits,
                         input int tx_wait, input logic [DS-1:0] txd, input int send_cut,
                         input int done_edges, output bit cut);
        logic [N-1:0] fr;
        bit           do_read;
        fr  = {cmd, pay};
        cut = 1'b0;
        step(1'b0, rb(), rb(), rd(), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < int'(N); i++) begin
            if (abort_bits == i) begin
                step(1'b1, rb(), rb(), rd(), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
                step(1'b1, rb(), rb(), rd(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                return;
            end
            if (i == int'(N) - 1) begin
                last_rx = fr;
                step(1'b0, fr[N-1-i], rb(), rd(), 1'b1, 1'b0, 1'b1,
                     (cmd == 2'b11) && !armed, 1'b0);
            end else begin
                step(1'b0, fr[N-1-i], rb(), rd(), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            end
        end
        do_read = (cmd == 2'b11) && armed;
        if (cmd == 2'b10) armed = 1'b1;
        if (cmd == 2'b11) armed = 1'b0;
        if (do_read) begin
            if (tx_wait >= int'(TO)) begin
                for (int k = 1; k <= int'(TO); k++)
                    step(1'b0, rb(), 1'b0, rd(), 1'b1, 1'b0, 1'b0, k == int'(TO), 1'b0);
            end else begin
                for (int k = 0; k < tx_wait; k++)
                    step(1'b0, rb(), 1'b0, rd(), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                step(1'b0, rb(), 1'b1, txd, 1'b1, txd[DS-1], 1'b0, 1'b0, 1'b1);
                for (int b = int'(DS) - 2; b >= 0; b--) begin
                    if (send_cut == int'(DS) - 2 - b) begin
                        cut = 1'b1;
                        return;
                    end
                    step(1'b0, rb(), rb(), rd(), 1'b1, txd[b], 1'b0, 1'b0, 1'b1);
                end
                step(1'b0, rb(), rb(), rd(), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            end
        end
        for (int k = 0; k < done_edges; k++)
            step(1'b0, rb(), rb(), rd(), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, rb(), rb(), rd(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, rb(), rb(), rd(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin : main
        bit cut;
        int ab, tw, sc;
        logic [1:0] c;

        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_miso", 32'(miso), 32'd0);
        chk("reset_rx_valid", 32'(rx_valid), 32'd0);
        chk("reset_rx_data", 32'(rx_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Write frame 00_1010_0101.
        rxv_cnt = 0;
        frame(2'b00, 8'hA5, -1, 0, 8'h00, -1, 3, cut);
        flush();
        chk("wr_rx_data", 32'(rx_data), 32'h0A5);
        chk("wr_rx_valid_pulses", 32'(rxv_cnt), 32'd1);

        // Deselect after E5 drops the frame.
        rxv_cnt = 0;
        frame(2'b01, 8'h5A, 5, 0, 8'h00, -1, 0, cut);
        flush();
        chk("abort_rx_valid_pulses", 32'(rxv_cnt), 32'd0);
        chk("abort_rx_data_held", 32'(rx_data), 32'h0A5);

        // Read address then read data, tx_valid on the third wait edge.
        frame(2'b10, 8'h03, -1, 0, 8'h00, -1, 1, cut);
        flush();
        chk("rd_addr_rx_data", 32'(rx_data), 32'h203);
        miso_bits = '0;
        tag_cnt   = 0;
        frame(2'b11, rd(), -1, 2, 8'hC3, -1, 2, cut);
        flush();
        chk("read_miso_bits", 32'(miso_bits), 32'hC3);
        chk("read_bit_count", 32'(tag_cnt), 32'd8);

        // tx_valid never arrives.
        frame(2'b10, rd(), -1, 0, 8'h00, -1, 0, cut);
        miso_hi_cnt = 0;
        frame(2'b11, rd(), -1, 20, 8'hFF, -1, 2, cut);
        flush();
        chk("timeout_miso_quiet", 32'(miso_hi_cnt), 32'd0);

        // tx_valid on the final wait edge still loads.
        frame(2'b10, rd(), -1, 0, 8'h00, -1, 0, cut);
        miso_bits = '0;
        frame(2'b11, rd(), -1, int'(TO) - 1, 8'h81, -1, 1, cut);
        flush();
        chk("late_load_miso_bits", 32'(miso_bits), 32'h81);

        // Reset during SEND bit 3.
        frame(2'b10, rd(), -1, 0, 8'h00, -1, 0, cut);
        frame(2'b11, rd(), -1, 1, 8'hFF, 3, 0, cut);
        chk("send_cut_reached", 32'(cut), 32'd1);
        flush();
        chk("pre_reset_miso", 32'(miso), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midsend_reset_miso", 32'(miso), 32'd0);
        chk("midsend_reset_busy", 32'(busy), 32'd0);
        chk("midsend_reset_rx_data", 32'(rx_data), 32'd0);
        armed   = 1'b0;
        last_rx = '0;
        ss_n    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Read data with no read address.
        rxv_cnt     = 0;
        miso_hi_cnt = 0;
        frame(2'b11, 8'h3C, -1, 0, 8'hFF, -1, 4, cut);
        flush();
        chk("noaddr_rx_valid_pulses", 32'(rxv_cnt), 32'd1);
        chk("noaddr_miso_quiet", 32'(miso_hi_cnt), 32'd0);
        chk("noaddr_rx_data", 32'(rx_data), 32'h33C);

        for (int t = 0; t < 80; t++) begin
            c  = 2'($urandom_range(0, 3));
            ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, N - 1)) : -1;
            tw = int'($urandom_range(0, 17));
            sc = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, DS - 2)) : -1;
            frame(c, rd(), ab, tw, rd(), sc, int'($urandom_range(0, 3)), cut);
            if (cut) begin
                step(1'b1, rb(), rb(), rd(), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
                step(1'b1, rb(), rb(), rd(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            end
        end
        flush();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
